// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks one result source, optionally extracts and
// extends a sub-word load, and registers the result into a 2-entry skid
// buffer with valid/ready handshakes toward the register file.
module wb_select_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NSRC    = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned MEM_IDX = 1,
  parameter int unsigned RA_W    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [NSRC*WIDTH-1:0] i_src_bus,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [1:0]            i_ld_size,
  input  logic                  i_ld_uns,
  input  logic [1:0]            i_ld_off,
  input  logic [RA_W-1:0]       i_in_rd,
  input  logic                  i_in_we,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [WIDTH-1:0]      o_out_data,
  output logic [RA_W-1:0]       o_out_rd,
  output logic                  o_out_we
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            r_state, w_state_next;
  logic              r_in_ready;
  logic [WIDTH-1:0]  r_a_data, r_b_data;
  logic [RA_W-1:0]   r_a_rd, r_b_rd;
  logic              r_a_we, r_b_we;

  logic [WIDTH-1:0]  w_sel_data;
  logic [WIDTH-1:0]  w_ext_data;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_is_mem;
  logic              w_fill_b, w_fill_h;
  logic              w_in_we_eff;
  logic              w_in_xfer, w_out_xfer;
  logic              w_load_a, w_load_b, w_a_from_b;

  // Source select; out-of-range codes fall back to source 0 (ALU).
  always_comb begin
    w_sel_data = i_src_bus[WIDTH-1:0];
    for (int i = 0; i < int'(NSRC); i++) begin
      if (i_sel == SEL_W'(i)) w_sel_data = i_src_bus[i*WIDTH +: WIDTH];
    end
  end

  // Sub-word extraction and sign/zero extension for the memory source only.
  always_comb begin
    w_is_mem = (i_sel == SEL_W'(MEM_IDX));
    w_byte   = 8'h00;
    unique case (i_ld_off)
      2'd0: w_byte = w_sel_data[7:0];
      2'd1: w_byte = w_sel_data[15:8];
      2'd2: w_byte = w_sel_data[23:16];
      2'd3: w_byte = w_sel_data[31:24];
      default: w_byte = 8'h00;
    endcase
    // Halfword lane comes from ld_off[1] only; ld_off[0] is ignored.
    w_half     = i_ld_off[1] ? w_sel_data[31:16] : w_sel_data[15:0];
    w_fill_b   = ~i_ld_uns & w_byte[7];
    w_fill_h   = ~i_ld_uns & w_half[15];
    w_ext_data = w_sel_data;
    if (w_is_mem) begin
      case (i_ld_size)
        2'b01:   w_ext_data = {{(WIDTH-16){w_fill_h}}, w_half};
        2'b10:   w_ext_data = {{(WIDTH-8){w_fill_b}}, w_byte};
        default: w_ext_data = w_sel_data;
      endcase
    end
  end

  assign w_in_we_eff = i_in_we & (i_in_rd != '0);
  assign w_in_xfer   = i_in_valid & r_in_ready;
  assign w_out_xfer  = o_out_valid & i_out_ready;

  // Skid-buffer next state and entry load controls.
  always_comb begin
    w_state_next = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_a_from_b   = 1'b0;
    unique case (r_state)
      StEmpty: begin
        if (w_in_xfer) begin
          w_state_next = StOne;
          w_load_a     = 1'b1;
        end
      end
      StOne: begin
        if (w_in_xfer && !w_out_xfer) begin
          w_state_next = StFull;
          w_load_b     = 1'b1;
        end else if (!w_in_xfer && w_out_xfer) begin
          w_state_next = StEmpty;
        end else if (w_in_xfer && w_out_xfer) begin
          w_load_a = 1'b1;
        end
      end
      StFull: begin
        // in_ready is low here, so only the drain side can move.
        if (w_out_xfer) begin
          w_state_next = StOne;
          w_a_from_b   = 1'b1;
        end
      end
      default: w_state_next = StEmpty;
    endcase
  end

  // State, ready and entry registers; reset discards all buffered entries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b0;
      r_a_data   <= '0;
      r_a_rd     <= '0;
      r_a_we     <= 1'b0;
      r_b_data   <= '0;
      r_b_rd     <= '0;
      r_b_we     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != StFull);
      if (w_load_a) begin
        r_a_data <= w_ext_data;
        r_a_rd   <= i_in_rd;
        r_a_we   <= w_in_we_eff;
      end else if (w_a_from_b) begin
        r_a_data <= r_b_data;
        r_a_rd   <= r_b_rd;
        r_a_we   <= r_b_we;
      end
      if (w_load_b) begin
        r_b_data <= w_ext_data;
        r_b_rd   <= i_in_rd;
        r_b_we   <= w_in_we_eff;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = (r_state != StEmpty);
  assign o_out_data  = r_a_data;
  assign o_out_rd    = r_a_rd;
  assign o_out_we    = r_a_we;

endmodule
